// File: rtl/br_fifo_shared_dynamic_pop_ctrl.sv
// Pop-side controller for a set of linked-list FIFOs that share one data RAM.
// Issues RAM reads round-robin under per-FIFO credits and stages returned data per FIFO.
module br_fifo_shared_dynamic_pop_ctrl #(
  parameter int unsigned NumFifos       = 2,
  parameter int unsigned Depth          = 3,
  parameter int unsigned Width          = 1,
  parameter int unsigned RamReadLatency = 1,
  parameter int unsigned StagingDepth   = RamReadLatency + 1,
  localparam int unsigned AddrWidth     = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntWidth      = $clog2(StagingDepth + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NumFifos-1:0]                head_valid,
  input  logic [NumFifos-1:0][AddrWidth-1:0] head,
  output logic [NumFifos-1:0]                head_advance,
  output logic                               data_ram_rd_addr_valid,
  output logic [AddrWidth-1:0]               data_ram_rd_addr,
  input  logic                               data_ram_rd_data_valid,
  input  logic [Width-1:0]                   data_ram_rd_data,
  output logic [NumFifos-1:0]                dealloc_valid,
  output logic [NumFifos-1:0][AddrWidth-1:0] dealloc_entry_id,
  output logic [NumFifos-1:0]                pop_valid,
  input  logic [NumFifos-1:0]                pop_ready,
  output logic [NumFifos-1:0][Width-1:0]     pop_data,
  output logic [NumFifos-1:0]                pop_empty
);

  localparam int unsigned FidWidth = (NumFifos > 1) ? $clog2(NumFifos) : 1;
  localparam int unsigned PtrWidth = (StagingDepth > 1) ? $clog2(StagingDepth) : 1;

  logic [NumFifos-1:0][CntWidth-1:0]                credit_q, credit_d;
  logic [NumFifos-1:0][CntWidth-1:0]                occ_q, occ_d;
  logic [NumFifos-1:0][PtrWidth-1:0]                rd_ptr_q, rd_ptr_d;
  logic [NumFifos-1:0][PtrWidth-1:0]                wr_ptr_q, wr_ptr_d;
  logic [NumFifos-1:0][StagingDepth-1:0][Width-1:0] stg_q, stg_d;
  logic [FidWidth-1:0]                              rr_ptr_q, rr_ptr_d;

  logic [NumFifos-1:0] pop_fire;
  logic [NumFifos-1:0] eligible;
  logic                grant_vld;
  logic [FidWidth-1:0] grant_fid;
  logic                ret_exp;
  logic [FidWidth-1:0] ret_fid;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(StagingDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle returns a credit, so a full FIFO may still issue.
  always_comb begin
    pop_fire = '0;
    eligible = '0;
    for (int f = 0; f < NumFifos; f++) begin
      pop_fire[f] = (occ_q[f] != '0) && pop_ready[f];
      eligible[f] = rst_n && head_valid[f] &&
                    ((credit_q[f] < CntWidth'(StagingDepth)) || pop_fire[f]);
    end
  end

  // Round-robin: first eligible FIFO at or after the priority pointer.
  always_comb begin
    logic [FidWidth-1:0] idx;
    grant_vld = 1'b0;
    grant_fid = '0;
    idx       = '0;
    for (int i = 0; i < NumFifos; i++) begin
      idx = FidWidth'((int'(rr_ptr_q) + i) % NumFifos);
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_fid = idx;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_fid == FidWidth'(NumFifos - 1)) ? '0 : grant_fid + 1'b1;
    end
  end

  always_comb begin
    head_advance           = '0;
    dealloc_valid          = '0;
    dealloc_entry_id       = '0;
    data_ram_rd_addr_valid = grant_vld;
    data_ram_rd_addr       = '0;
    if (grant_vld) begin
      head_advance[grant_fid]     = 1'b1;
      dealloc_valid[grant_fid]    = 1'b1;
      dealloc_entry_id[grant_fid] = head[grant_fid];
      data_ram_rd_addr            = head[grant_fid];
    end
  end

  // FIFO id of each outstanding read, aligned with the RAM return.
  if (RamReadLatency == 0) begin : g_lat0
    assign ret_exp = grant_vld;
    assign ret_fid = grant_fid;
  end else begin : g_pipe
    logic [RamReadLatency-1:0]               vld_q, vld_d;
    logic [RamReadLatency-1:0][FidWidth-1:0] fid_q, fid_d;

    always_comb begin
      vld_d    = vld_q;
      fid_d    = fid_q;
      vld_d[0] = grant_vld;
      fid_d[0] = grant_fid;
      for (int s = 1; s < RamReadLatency; s++) begin
        vld_d[s] = vld_q[s-1];
        fid_d[s] = fid_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        fid_q <= '0;
      end else begin
        vld_q <= vld_d;
        fid_q <= fid_d;
      end
    end

    assign ret_exp = vld_q[RamReadLatency-1];
    assign ret_fid = fid_q[RamReadLatency-1];
  end

  // Credit and staging buffer bookkeeping.
  always_comb begin
    logic ret_f;
    logic iss_f;
    credit_d = credit_q;
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    stg_d    = stg_q;
    ret_f    = 1'b0;
    iss_f    = 1'b0;
    for (int f = 0; f < NumFifos; f++) begin
      ret_f       = data_ram_rd_data_valid && (ret_fid == FidWidth'(f));
      iss_f       = grant_vld && (grant_fid == FidWidth'(f));
      credit_d[f] = credit_q[f] + CntWidth'(iss_f) - CntWidth'(pop_fire[f]);
      occ_d[f]    = occ_q[f] + CntWidth'(ret_f) - CntWidth'(pop_fire[f]);
      if (ret_f) begin
        stg_d[f][wr_ptr_q[f]] = data_ram_rd_data;
        wr_ptr_d[f]           = ptr_inc(wr_ptr_q[f]);
      end
      if (pop_fire[f]) begin
        rd_ptr_d[f] = ptr_inc(rd_ptr_q[f]);
      end
    end
  end

  always_comb begin
    pop_valid = '0;
    pop_data  = '0;
    pop_empty = '0;
    for (int f = 0; f < NumFifos; f++) begin
      pop_valid[f] = (occ_q[f] != '0);
      pop_data[f]  = stg_q[f][rd_ptr_q[f]];
      pop_empty[f] = !head_valid[f] && (credit_q[f] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      stg_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      credit_q <= credit_d;
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      stg_q    <= stg_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  a_ret_match: assert property (@(posedge clk) disable iff (!rst_n)
    data_ram_rd_data_valid == ret_exp);
  a_adv_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(head_advance));
  for (genvar g = 0; g < NumFifos; g++) begin : g_chk
    a_credit_max: assert property (@(posedge clk) disable iff (!rst_n)
      credit_q[g] <= CntWidth'(StagingDepth));
  end

endmodule

// File: tb/tb_br_fifo_shared_dynamic_pop_ctrl.sv
// Scoreboard bench for br_fifo_shared_dynamic_pop_ctrl: latency-1 instance plus a latency-0 instance.
module tb_br_fifo_shared_dynamic_pop_ctrl;
  localparam int unsigned NF = 2, DEPTH = 16, AW = 4, W = 8, SD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NF-1:0]         head_valid, head_advance, dealloc_valid, pop_valid, pop_ready, pop_empty;
  logic [NF-1:0][AW-1:0] head, dealloc_entry_id;
  logic                  rd_addr_valid, rd_data_valid;
  logic [AW-1:0]         rd_addr;
  logic [W-1:0]          rd_data;
  logic [NF-1:0][W-1:0]  pop_data;

  logic [NF-1:0]         z_head_valid, z_head_advance, z_dealloc_valid, z_pop_valid, z_pop_ready, z_pop_empty;
  logic [NF-1:0][AW-1:0] z_head, z_dealloc_entry_id;
  logic                  z_rd_addr_valid, z_rd_data_valid;
  logic [AW-1:0]         z_rd_addr;
  logic [W-1:0]          z_rd_data;
  logic [NF-1:0][W-1:0]  z_pop_data;

  br_fifo_shared_dynamic_pop_ctrl #(
    .NumFifos(NF), .Depth(DEPTH), .Width(W), .RamReadLatency(1), .StagingDepth(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .head_valid(head_valid), .head(head), .head_advance(head_advance),
    .data_ram_rd_addr_valid(rd_addr_valid), .data_ram_rd_addr(rd_addr),
    .data_ram_rd_data_valid(rd_data_valid), .data_ram_rd_data(rd_data),
    .dealloc_valid(dealloc_valid), .dealloc_entry_id(dealloc_entry_id),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data), .pop_empty(pop_empty)
  );

  br_fifo_shared_dynamic_pop_ctrl #(
    .NumFifos(NF), .Depth(DEPTH), .Width(W), .RamReadLatency(0)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .head_valid(z_head_valid), .head(z_head), .head_advance(z_head_advance),
    .data_ram_rd_addr_valid(z_rd_addr_valid), .data_ram_rd_addr(z_rd_addr),
    .data_ram_rd_data_valid(z_rd_data_valid), .data_ram_rd_data(z_rd_data),
    .dealloc_valid(z_dealloc_valid), .dealloc_entry_id(z_dealloc_entry_id),
    .pop_valid(z_pop_valid), .pop_ready(z_pop_ready), .pop_data(z_pop_data), .pop_empty(z_pop_empty)
  );

  function automatic logic [W-1:0] mem_val(input logic [AW-1:0] a);
    return W'(32'(a) * 37 + 11);
  endfunction

  // RAM models: one-cycle registered read, and a combinational read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_data_valid <= rd_addr_valid;
      rd_data       <= mem_val(rd_addr);
    end
  end
  assign z_rd_data_valid = z_rd_addr_valid;
  assign z_rd_data       = mem_val(z_rd_addr);

  int n_chk = 0;
  int n_fail = 0;
  int pop_cnt [NF];
  logic [AW-1:0] hq [NF][$];
  logic [W-1:0]  exp_q [NF][$];

  logic [NF-1:0]         o_adv, o_dv, o_pv, o_pe;
  logic                  o_rv;
  logic [AW-1:0]         o_addr;
  logic [NF-1:0][AW-1:0] o_did;
  logic [NF-1:0][W-1:0]  o_pd;

  // One cycle on the main DUT: drive heads, sample, run the scoreboard.
  task automatic tick();
    int sz;
    logic popped;
    logic [W-1:0] e;
    for (int f = 0; f < NF; f++) begin
      head_valid[f] = hq[f].size() > 0;
      head[f]       = (hq[f].size() > 0) ? hq[f][0] : '0;
    end
    #1;
    o_adv = head_advance; o_dv = dealloc_valid; o_pv = pop_valid; o_pe = pop_empty;
    o_rv = rd_addr_valid; o_addr = rd_addr; o_did = dealloc_entry_id; o_pd = pop_data;
    n_chk++;
    if (!$onehot0(o_adv) || (o_rv !== (o_adv != '0))) begin
      n_fail++;
      $display("FAIL grant_onehot: head_advance=%b rd_addr_valid=%b", o_adv, o_rv);
    end
    for (int f = 0; f < NF; f++) begin
      sz = exp_q[f].size();
      popped = o_pv[f] && pop_ready[f];
      n_chk++;
      if (o_pe[f] !== ((hq[f].size() == 0) && (sz == 0))) begin
        n_fail++;
        $display("FAIL pop_empty[%0d]: got=%b exp=%b", f, o_pe[f], (hq[f].size() == 0) && (sz == 0));
      end
      if (popped) begin
        n_chk++;
        pop_cnt[f]++;
        if (exp_q[f].size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected[%0d]: got data=%0d exp=no pop", f, o_pd[f]);
        end else begin
          e = exp_q[f].pop_front();
          if (o_pd[f] !== e) begin
            n_fail++;
            $display("FAIL pop_data[%0d]: got=%0d exp=%0d", f, o_pd[f], e);
          end
        end
      end
      if (o_adv[f]) begin
        n_chk++;
        if (o_did[f] !== head[f] || o_dv[f] !== 1'b1 || o_addr !== head[f] || (sz >= SD && !popped)) begin
          n_fail++;
          $display("FAIL issue[%0d]: got addr=%0d dealloc=%b id=%0d credit=%0d exp addr=id=%0d credit<%0d or pop",
                   f, o_addr, o_dv[f], o_did[f], sz, head[f], SD);
        end
        exp_q[f].push_back(mem_val(head[f]));
        void'(hq[f].pop_front());
      end else if (o_dv[f]) begin
        n_chk++;
        n_fail++;
        $display("FAIL dealloc_stray[%0d]: got dealloc_valid=1 exp=0", f);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pop_ready = '0;
    head_valid = '0;
    head = '0;
    for (int f = 0; f < NF; f++) begin
      hq[f].delete();
      exp_q[f].delete();
      pop_cnt[f] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    head_valid = 2'b01;
    head[0] = 4'd3;
    pop_ready = 2'b11;
    #1;
    n_chk++;
    if (pop_valid !== 2'b00 || head_advance !== 2'b00 || dealloc_valid !== 2'b00 || rd_addr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pv=%b adv=%b dv=%b rv=%b exp all 0", pop_valid, head_advance, dealloc_valid, rd_addr_valid);
    end
    n_chk++;
    if (pop_empty !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_pop_empty: got=%b exp=10", pop_empty);
    end
    n_chk++;
    if (z_pop_valid !== 2'b00 || z_rd_addr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_z: got pv=%b rv=%b exp 0", z_pop_valid, z_rd_addr_valid);
    end
  endtask

  task automatic test_single();
    int iss_c[$], pop_c[$];
    logic [AW-1:0] iss_a[$], dl_a[$];
    logic [W-1:0] pop_d[$];
    do_reset();
    hq[0].push_back(4'd5);
    hq[0].push_back(4'd2);
    pop_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o_adv[0]) begin iss_c.push_back(c); iss_a.push_back(o_addr); end
      if (o_dv[0]) dl_a.push_back(o_did[0]);
      if (o_pv[0]) begin pop_c.push_back(c); pop_d.push_back(o_pd[0]); end
    end
    n_chk++;
    if (iss_c.size() != 2 || iss_c[0] != 0 || iss_c[1] != 1 || iss_a[0] !== 4'd5 || iss_a[1] !== 4'd2) begin
      n_fail++;
      $display("FAIL single_issue: got n=%0d c=%0d,%0d a=%0d,%0d exp n=2 c=0,1 a=5,2",
               iss_c.size(), iss_c[0], iss_c[1], iss_a[0], iss_a[1]);
    end
    n_chk++;
    if (dl_a.size() != 2 || dl_a[0] !== 4'd5 || dl_a[1] !== 4'd2) begin
      n_fail++;
      $display("FAIL single_dealloc: got n=%0d id=%0d,%0d exp n=2 id=5,2", dl_a.size(), dl_a[0], dl_a[1]);
    end
    n_chk++;
    if (pop_c.size() != 2 || pop_c[0] != 2 || pop_c[1] != 3 || pop_d[0] !== mem_val(4'd5) || pop_d[1] !== mem_val(4'd2)) begin
      n_fail++;
      $display("FAIL single_pop: got n=%0d c=%0d,%0d d=%0d,%0d exp n=2 c=2,3 d=%0d,%0d",
               pop_c.size(), pop_c[0], pop_c[1], pop_d[0], pop_d[1], mem_val(4'd5), mem_val(4'd2));
    end
  endtask

  task automatic test_round_robin();
    logic [NF-1:0] ea, ep;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      hq[0].push_back(AW'(k));
      hq[1].push_back(AW'(k + 6));
    end
    pop_ready = 2'b11;
    for (int c = 0; c < 10; c++) begin
      tick();
      ea = (c % 2 == 0) ? 2'b01 : 2'b10;
      n_chk++;
      if (o_adv !== ea) begin
        n_fail++;
        $display("FAIL rr_grant c=%0d: got=%b exp=%b", c, o_adv, ea);
      end
      if (c >= 2) begin
        ep = (c % 2 == 0) ? 2'b01 : 2'b10;
        n_chk++;
        if (o_pv !== ep) begin
          n_fail++;
          $display("FAIL rr_pop_valid c=%0d: got=%b exp=%b", c, o_pv, ep);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n1;
    logic have;
    logic [W-1:0] held;
    logic [NF-1:0] ea;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      hq[0].push_back(AW'(k));
      hq[1].push_back(AW'(15 - k));
    end
    pop_ready = 2'b01;
    n1 = 0;
    have = 1'b0;
    held = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_adv[1]) n1++;
      if (c >= 4) begin
        n_chk++;
        if (o_adv !== 2'b01) begin
          n_fail++;
          $display("FAIL bp_fifo0_rate c=%0d: got=%b exp=01", c, o_adv);
        end
      end
      if (o_pv[1]) begin
        if (have) begin
          n_chk++;
          if (o_pd[1] !== held) begin
            n_fail++;
            $display("FAIL bp_data_stable c=%0d: got=%0d exp=%0d", c, o_pd[1], held);
          end
        end else begin
          held = o_pd[1];
          have = 1'b1;
        end
      end
    end
    n_chk++;
    if (n1 != 2) begin
      n_fail++;
      $display("FAIL bp_fifo1_issues: got=%0d exp=2", n1);
    end
    pop_ready = 2'b11;
    for (int c = 10; c < 18; c++) begin
      tick();
      ea = (c % 2 == 0) ? 2'b10 : 2'b01;
      n_chk++;
      if (o_adv !== ea) begin
        n_fail++;
        $display("FAIL bp_resume c=%0d: got=%b exp=%b", c, o_adv, ea);
      end
    end
  endtask

  task automatic test_zero_latency();
    logic [AW-1:0] zq[$];
    logic [W-1:0]  zexp[$];
    logic [W-1:0]  e;
    int npop, first, last;
    do_reset();
    for (int k = 0; k < 10; k++) zq.push_back(AW'(k + 3));
    z_pop_ready = 2'b01;
    npop = 0;
    first = -1;
    last = -1;
    for (int c = 0; c < 14; c++) begin
      z_head_valid = {1'b0, zq.size() > 0};
      z_head[0] = (zq.size() > 0) ? zq[0] : '0;
      #1;
      if (z_pop_valid[0] && z_pop_ready[0]) begin
        n_chk++;
        npop++;
        if (first < 0) first = c;
        last = c;
        if (zexp.size() == 0) begin
          n_fail++;
          $display("FAIL z_pop_unexpected c=%0d: got data=%0d exp=no pop", c, z_pop_data[0]);
        end else begin
          e = zexp.pop_front();
          if (z_pop_data[0] !== e) begin
            n_fail++;
            $display("FAIL z_pop_data c=%0d: got=%0d exp=%0d", c, z_pop_data[0], e);
          end
        end
      end
      if (z_head_advance[0]) begin
        n_chk++;
        if (z_rd_addr !== z_head[0]) begin
          n_fail++;
          $display("FAIL z_issue_addr c=%0d: got=%0d exp=%0d", c, z_rd_addr, z_head[0]);
        end
        zexp.push_back(mem_val(z_head[0]));
        void'(zq.pop_front());
      end
      @(negedge clk);
    end
    n_chk++;
    if (npop != 10 || first != 1 || last != 10) begin
      n_fail++;
      $display("FAIL z_throughput: got pops=%0d first=%0d last=%0d exp 10,1,10", npop, first, last);
    end
    z_head_valid = '0;
    z_pop_ready = '0;
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    hq[0].push_back(4'd1); hq[0].push_back(4'd2); hq[0].push_back(4'd3);
    hq[1].push_back(4'd9); hq[1].push_back(4'd10);
    pop_ready = 2'b00;
    repeat (3) tick();
    head_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (pop_valid !== 2'b00 || dealloc_valid !== 2'b00 || head_advance !== 2'b00 || rd_addr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got pv=%b dv=%b adv=%b rv=%b exp all 0", pop_valid, dealloc_valid, head_advance, rd_addr_valid);
    end
    n_chk++;
    if (pop_empty !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_empty_hv11: got=%b exp=00", pop_empty);
    end
    head_valid = 2'b10;
    @(negedge clk);
    n_chk++;
    if (pop_empty !== 2'b01 || pop_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_empty_hv10: got empty=%b pv=%b exp empty=01 pv=00", pop_empty, pop_valid);
    end
    for (int f = 0; f < NF; f++) begin
      hq[f].delete();
      exp_q[f].delete();
    end
    rst_n = 1'b1;
    hq[0].push_back(4'd7);
    pop_ready = 2'b01;
    p0 = pop_cnt[0];
    repeat (4) tick();
    n_chk++;
    if (pop_cnt[0] - p0 != 1 || exp_q[0].size() != 0 || o_pe !== 2'b11) begin
      n_fail++;
      $display("FAIL post_reset: got pops=%0d pending=%0d empty=%b exp 1,0,11", pop_cnt[0] - p0, exp_q[0].size(), o_pe);
    end
  endtask

  initial begin
    pop_ready = '0;
    head_valid = '0;
    head = '0;
    z_head_valid = '0;
    z_head = '0;
    z_pop_ready = '0;
    for (int f = 0; f < NF; f++) pop_cnt[f] = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero_latency();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
